boot_copy_sequencer: RTL and testbench
======================================

Name: boot_copy_sequencer

Overview:
Sequences the boot-time image copy from QSPI flash (AXI slave at 0x2000) into instruction BRAM (0x4000). Acts as a single-outstanding AXI4-Lite master: one read, then one write per 32-bit word. Holds the CV32E40P core in fetch-disable until the copy completes, then raises cpu_fetch_enable for the rest of the session. Sits between the reset tree, the AXI interconnect master port and the core's fetch_enable input.

Parameters:
SRC_BASE, 32'h0000_2000, byte address of first source word (flash controller window)
DST_BASE, 32'h0000_4000, byte address of first destination word (instruction BRAM)
WORD_COUNT, 2048, number of 32-bit words copied (8 KiB, fills 0x4000-0x5FFF); legal range 1..65535
START_DELAY, 16, sys_clock cycles waited after reset release before the first read

Ports:
sys_clock  in  1  system clock, 100 MHz; all logic on rising edge
reset  in  1  asynchronous, active-high reset
m_axi_araddr  out  32  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axi_awaddr  out  32  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  write strobes, constant 4'hF
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
cpu_fetch_enable  out  1  core fetch enable; high only after a successful copy
boot_error  out  1  sticky: a non-OKAY response aborted the copy
words_copied  out  16  count of words whose write has received BRESP=OKAY

Behaviour:
- Reset (async assert, sync deassert by the reset tree): state=WAIT; all valid/ready outputs 0; cpu_fetch_enable=0; boot_error=0; words_copied=0; address/data outputs 0; word index=0; delay counter=0.
- Reset mid-copy aborts immediately to the reset state. A restart repeats the copy from word 0. A pending slave response after reset is not tracked.
- WAIT: counts START_DELAY cycles, then -> RD_ADDR.
- RD_ADDR: araddr=SRC_BASE+4*idx, arvalid=1. Held stable until arvalid&&arready, then -> RD_DATA.
- RD_DATA: rready=1. On rvalid: if rresp!=2'b00 -> ERROR; else latch rdata into wdata -> WR.
- WR: awaddr=DST_BASE+4*idx, awvalid=1, wvalid=1 asserted in the same cycle. Each valid drops independently once its own handshake completes (aw_done/w_done flags). When both are done -> WR_RESP. The slave may accept AW and W in either order or in the same cycle.
- WR_RESP: bready=1. On bvalid: if bresp!=OKAY -> ERROR; else words_copied+=1 and idx+=1. If idx was WORD_COUNT-1 -> DONE, else -> RD_ADDR.
- Minimum latency per word: 5 cycles (AR, R, AW/W, B, transition) with zero-wait slaves.
- DONE: cpu_fetch_enable=1 from the first cycle in DONE. All AXI valids/readies stay 0. Terminal until reset.
- ERROR: boot_error=1, cpu_fetch_enable stays 0, AXI idle. Terminal until reset.
- Addresses are 32-bit modulo-2^32 sums. idx is 16 bits. No wrap occurs within the legal WORD_COUNT range.
- Outputs are registered; no combinational path from AXI inputs to AXI outputs.
- At most one AXI transaction is outstanding at any time. Read and write phases never overlap.

Test Plan:
- Zero-wait slaves, WORD_COUNT=4, flash words 0xA0..0xA3 -> BRAM 0x4000..0x400C receive 0xA0..0xA3 in order with wstrb=4'hF; words_copied=4; cpu_fetch_enable rises exactly START_DELAY + 4*5 cycles after reset release.
- Random ready/valid back-pressure (0-7 cycles) on all channels, WORD_COUNT=64 -> araddr/awaddr/wdata stable while valid is high; every word is correct; cpu_fetch_enable=1 only after the 64th BRESP.
- AW accepted 3 cycles before W, then W accepted 3 cycles before AW -> exactly one AW and one W handshake per word; no duplicate writes.
- RRESP=2'b10 on word 2 -> boot_error=1, words_copied=2, no write to 0x4008, cpu_fetch_enable remains 0 for 1000 cycles.
- BRESP=2'b11 on the last word (WORD_COUNT=4) -> boot_error=1, words_copied=3, cpu_fetch_enable=0.
- Reset asserted during word 10 of 64, released after 5 cycles -> all outputs return to reset values asynchronously; copy restarts at araddr=0x2000; completes with words_copied=64.

Source files
------------

// File: rtl/boot_copy_sequencer.sv
// Boot-time image copier: single-outstanding AXI4-Lite master that moves WORD_COUNT words
// from flash to instruction BRAM, then releases the core's fetch enable.
module boot_copy_sequencer #(
    parameter logic [31:0] SRC_BASE    = 32'h0000_2000,
    parameter logic [31:0] DST_BASE    = 32'h0000_4000,
    parameter int          WORD_COUNT  = 2048,
    parameter int          START_DELAY = 16
) (
    input  logic        sys_clock,
    input  logic        reset,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        cpu_fetch_enable,
    output logic        boot_error,
    output logic [15:0] words_copied
);

    localparam logic [15:0] LAST_IDX      = 16'(WORD_COUNT - 1);
    localparam logic [31:0] START_DELAY_U = 32'(START_DELAY);
    localparam logic [1:0]  RESP_OKAY     = 2'b00;

    typedef enum logic [2:0] {
        S_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_WR_RESP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_reg;
    logic [15:0] idx_reg;
    logic [15:0] words_reg;
    logic [31:0] delay_cnt_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic [31:0] araddr_reg;
    logic        arvalid_reg;
    logic        rready_reg;
    logic [31:0] awaddr_reg;
    logic        awvalid_reg;
    logic [31:0] wdata_reg;
    logic        wvalid_reg;
    logic        bready_reg;
    logic        fetch_en_reg;
    logic        boot_error_reg;
    logic [15:0] idx_next;

    assign idx_next = idx_reg + 16'd1;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_WAIT;
            idx_reg        <= '0;
            words_reg      <= '0;
            delay_cnt_reg  <= '0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            araddr_reg     <= '0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            awaddr_reg     <= '0;
            awvalid_reg    <= 1'b0;
            wdata_reg      <= '0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            fetch_en_reg   <= 1'b0;
            boot_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (delay_cnt_reg + 32'd1 >= START_DELAY_U) begin
                        araddr_reg  <= word_addr(SRC_BASE, idx_reg);
                        arvalid_reg <= 1'b1;
                        state_reg   <= S_RD_ADDR;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg + 32'd1;
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rready_reg <= 1'b0;
                        if (m_axi_rresp != RESP_OKAY) begin
                            boot_error_reg <= 1'b1;
                            state_reg      <= S_ERROR;
                        end else begin
                            wdata_reg   <= m_axi_rdata;
                            awaddr_reg  <= word_addr(DST_BASE, idx_reg);
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= S_WR;
                        end
                    end
                end
                // AW and W complete independently; the slave may take them in any order.
                S_WR: begin
                    if (aw_done_reg && w_done_reg) begin
                        bready_reg <= 1'b1;
                        state_reg  <= S_WR_RESP;
                    end else begin
                        if (awvalid_reg && m_axi_awready) begin
                            awvalid_reg <= 1'b0;
                            aw_done_reg <= 1'b1;
                        end
                        if (wvalid_reg && m_axi_wready) begin
                            wvalid_reg <= 1'b0;
                            w_done_reg <= 1'b1;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_reg <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) begin
                            boot_error_reg <= 1'b1;
                            state_reg      <= S_ERROR;
                        end else begin
                            words_reg <= words_reg + 16'd1;
                            idx_reg   <= idx_next;
                            if (idx_reg == LAST_IDX) begin
                                fetch_en_reg <= 1'b1;
                                state_reg    <= S_DONE;
                            end else begin
                                araddr_reg  <= word_addr(SRC_BASE, idx_next);
                                arvalid_reg <= 1'b1;
                                state_reg   <= S_RD_ADDR;
                            end
                        end
                    end
                end
                S_DONE:  state_reg <= S_DONE;
                S_ERROR: state_reg <= S_ERROR;
                default: begin
                    boot_error_reg <= 1'b1;
                    state_reg      <= S_ERROR;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wstrb
            assign m_axi_wstrb[gi] = 1'b1;
        end
    endgenerate

    assign m_axi_araddr     = araddr_reg;
    assign m_axi_arvalid    = arvalid_reg;
    assign m_axi_rready     = rready_reg;
    assign m_axi_awaddr     = awaddr_reg;
    assign m_axi_awvalid    = awvalid_reg;
    assign m_axi_wdata      = wdata_reg;
    assign m_axi_wvalid     = wvalid_reg;
    assign m_axi_bready     = bready_reg;
    assign cpu_fetch_enable = fetch_en_reg;
    assign boot_error       = boot_error_reg;
    assign words_copied     = words_reg;

endmodule

// File: tb/tb_boot_copy_sequencer.sv
// Bench: two sequencer instances (4 and 64 words) behind one AXI slave model;
// only the selected instance is out of reset at any time.
module tb_boot_copy_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v [2];
    logic sel;

    logic [31:0] araddr_v [2];
    logic        arvalid_v [2];
    logic        rready_v [2];
    logic [31:0] awaddr_v [2];
    logic        awvalid_v [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  wstrb_v [2];
    logic        wvalid_v [2];
    logic        bready_v [2];
    logic        fe_v [2];
    logic        err_v [2];
    logic [15:0] wc_v [2];

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            boot_copy_sequencer #(
                .WORD_COUNT ((gi == 0) ? 4 : 64)
            ) u_dut (
                .sys_clock        (clk),
                .reset            (rst_v[gi]),
                .m_axi_araddr     (araddr_v[gi]),
                .m_axi_arvalid    (arvalid_v[gi]),
                .m_axi_arready    (arready),
                .m_axi_rdata      (rdata),
                .m_axi_rresp      (rresp),
                .m_axi_rvalid     (rvalid),
                .m_axi_rready     (rready_v[gi]),
                .m_axi_awaddr     (awaddr_v[gi]),
                .m_axi_awvalid    (awvalid_v[gi]),
                .m_axi_awready    (awready),
                .m_axi_wdata      (wdata_v[gi]),
                .m_axi_wstrb      (wstrb_v[gi]),
                .m_axi_wvalid     (wvalid_v[gi]),
                .m_axi_wready     (wready),
                .m_axi_bresp      (bresp),
                .m_axi_bvalid     (bvalid),
                .m_axi_bready     (bready_v[gi]),
                .cpu_fetch_enable (fe_v[gi]),
                .boot_error       (err_v[gi]),
                .words_copied     (wc_v[gi])
            );
        end
    endgenerate

    // Selected instance view
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready, fe, berr, act_rst;
    logic [15:0] wc;
    always_comb begin
        araddr  = araddr_v[sel];
        arvalid = arvalid_v[sel];
        rready  = rready_v[sel];
        awaddr  = awaddr_v[sel];
        awvalid = awvalid_v[sel];
        wdata   = wdata_v[sel];
        wstrb   = wstrb_v[sel];
        wvalid  = wvalid_v[sel];
        bready  = bready_v[sel];
        fe      = fe_v[sel];
        berr    = err_v[sel];
        wc      = wc_v[sel];
        act_rst = rst_v[sel];
    end

    // ---------------- AXI slave model ----------------
    int ar_cfg, r_cfg, aw_cfg, w_cfg, b_cfg;   // <0: random 0..7 wait cycles
    int rd_err_idx, wr_err_idx;
    logic [31:0] flash [64];

    int cyc = 0;
    int ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic r_pending, b_pending, aw_got, w_got;
    logic [31:0] aw_addr_c, w_data_c;
    logic [3:0]  w_strb_c;
    int aw_cyc, w_cyc;
    int ar_cnt, aw_cnt, w_cnt, b_ok_cnt, stab_err;
    logic [31:0] first_araddr;
    logic p_arvalid, p_ar_hs, p_awvalid, p_aw_hs, p_wvalid, p_w_hs;
    logic [31:0] p_araddr, p_awaddr, p_wdata;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  skew_q[$];

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 7)) : cfg;
    endfunction

    logic ar_hs, aw_hs, w_hs, wr_complete;
    logic [31:0] ar_word, cur_awaddr, cur_wdata, wr_word;
    logic [3:0]  cur_wstrb;
    int cur_aw_cyc, cur_w_cyc;

    assign arready     = (ar_dly == 0);
    assign awready     = (aw_dly == 0);
    assign wready      = (w_dly == 0);
    assign rvalid      = r_pending && (r_dly == 0);
    assign bvalid      = b_pending && (b_dly == 0);
    assign ar_hs       = arvalid && arready;
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_word     = (araddr - 32'h2000) >> 2;
    assign cur_awaddr  = aw_hs ? awaddr : aw_addr_c;
    assign cur_wdata   = w_hs ? wdata : w_data_c;
    assign cur_wstrb   = w_hs ? wstrb : w_strb_c;
    assign cur_aw_cyc  = aw_hs ? cyc : aw_cyc;
    assign cur_w_cyc   = w_hs ? cyc : w_cyc;
    assign wr_word     = (cur_awaddr - 32'h4000) >> 2;
    assign wr_complete = (aw_got || aw_hs) && (w_got || w_hs) && (aw_hs || w_hs);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (act_rst) begin
            r_pending <= 1'b0; b_pending <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            ar_dly <= pick(ar_cfg); r_dly <= 0; aw_dly <= pick(aw_cfg);
            w_dly <= pick(w_cfg); b_dly <= 0;
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_ok_cnt <= 0; stab_err <= 0;
            first_araddr <= '1;
            p_arvalid <= 1'b0; p_awvalid <= 1'b0; p_wvalid <= 1'b0;
        end else begin
            p_arvalid <= arvalid; p_ar_hs <= ar_hs; p_araddr <= araddr;
            p_awvalid <= awvalid; p_aw_hs <= aw_hs; p_awaddr <= awaddr;
            p_wvalid  <= wvalid;  p_w_hs  <= w_hs;  p_wdata  <= wdata;
            if ((p_arvalid && !p_ar_hs && (!arvalid || araddr !== p_araddr)) ||
                (p_awvalid && !p_aw_hs && (!awvalid || awaddr !== p_awaddr)) ||
                (p_wvalid && !p_w_hs && (!wvalid || wdata !== p_wdata)))
                stab_err <= stab_err + 1;

            if (r_pending) begin
                if (r_dly > 0) r_dly <= r_dly - 1;
                else if (rready) r_pending <= 1'b0;
            end
            if (ar_hs) begin
                r_pending <= 1'b1;
                r_dly     <= pick(r_cfg);
                rdata     <= flash[ar_word[5:0]];
                rresp     <= (ar_word == 32'(rd_err_idx)) ? 2'b10 : 2'b00;
                ar_dly    <= pick(ar_cfg);
                ar_cnt    <= ar_cnt + 1;
                if (ar_cnt == 0) first_araddr <= araddr;
            end else if (arvalid && ar_dly > 0) begin
                ar_dly <= ar_dly - 1;
            end

            if (aw_hs) begin
                aw_got <= 1'b1; aw_addr_c <= awaddr; aw_cyc <= cyc;
                aw_dly <= pick(aw_cfg); aw_cnt <= aw_cnt + 1;
            end else if (awvalid && aw_dly > 0) begin
                aw_dly <= aw_dly - 1;
            end
            if (w_hs) begin
                w_got <= 1'b1; w_data_c <= wdata; w_strb_c <= wstrb; w_cyc <= cyc;
                w_dly <= pick(w_cfg); w_cnt <= w_cnt + 1;
            end else if (wvalid && w_dly > 0) begin
                w_dly <= w_dly - 1;
            end

            if (b_pending) begin
                if (b_dly > 0) b_dly <= b_dly - 1;
                else if (bready) begin
                    b_pending <= 1'b0;
                    if (bresp == 2'b00) b_ok_cnt <= b_ok_cnt + 1;
                end
            end
            if (wr_complete) begin
                obs_q.push_back({cur_awaddr, cur_wdata, cur_wstrb});
                skew_q.push_back(cur_w_cyc - cur_aw_cyc);
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
                b_pending <= 1'b1;
                b_dly     <= pick(b_cfg);
                bresp     <= (wr_word == 32'(wr_err_idx)) ? 2'b11 : 2'b00;
            end
        end
    end

    // ---------------- Test sequencing ----------------
    int   n_cmp = 0;
    int   n_fail = 0;
    wr_t  got, want;
    int   sk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int a, input int r, input int aw, input int w, input int b);
        ar_cfg = a; r_cfg = r; aw_cfg = aw; w_cfg = w; b_cfg = b;
    endtask

    // Resets both instances, loads flash, queues expected writes, releases the selected one.
    task automatic begin_run(input logic s, input int n_exp, input bit seq_data);
        sel = s;
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        for (int i = 0; i < 64; i++) flash[i] = seq_data ? 32'hA0 + 32'(i) : $urandom;
        obs_q.delete(); skew_q.delete(); exp_q.delete();
        for (int i = 0; i < n_exp; i++) exp_q.push_back({32'h4000 + 32'(4 * i), flash[i], 4'hF});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_v[s] = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        tick();
        n_cmp++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b, want 00000", {arvalid, rready, awvalid, wvalid, bready});
        end
        n_cmp++;
        if ({fe, berr} !== 2'b00) begin
            n_fail++; $display("FAIL reset_status: fetch/err got %b, want 00", {fe, berr});
        end
        n_cmp++;
        if (wc !== 16'd0) begin
            n_fail++; $display("FAIL reset_words: got %0d, want 0", wc);
        end
        n_cmp++;
        if ({araddr, awaddr, wdata} !== 96'd0) begin
            n_fail++; $display("FAIL reset_addr_data: araddr=%h awaddr=%h wdata=%h, want all 0", araddr, awaddr, wdata);
        end
    endtask

    task automatic test_zero_wait();
        int rise = 0;
        set_cfg(0, 0, 0, 0, 0); rd_err_idx = -1; wr_err_idx = -1;
        begin_run(1'b0, 4, 1'b1);
        for (int c = 1; c <= 200 && rise == 0; c++) begin
            tick();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front(); sk = skew_q.pop_front();
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++; $display("FAIL zero_wait_write: got %h/%h/%h, want %h/%h/%h", got.addr, got.data, got.strb, want.addr, want.data, want.strb);
                end
            end
            if (fe) rise = c;
        end
        n_cmp++;
        if (rise != 36) begin
            n_fail++; $display("FAIL zero_wait_latency: fetch_enable rose at cycle %0d, want 36", rise);
        end
        n_cmp++;
        if (wc !== 16'd4 || berr !== 1'b0 || exp_q.size() != 0 || aw_cnt != 4) begin
            n_fail++; $display("FAIL zero_wait_final: words=%0d err=%b unwritten=%0d aw=%0d, want 4/0/0/4", wc, berr, exp_q.size(), aw_cnt);
        end
    endtask

    task automatic test_aw_w_order();
        for (int m = 0; m < 2; m++) begin
            int skew_bad = 0;
            int want_skew = (m == 0) ? 3 : -3;
            set_cfg(0, 0, (m == 0) ? 0 : 3, (m == 0) ? 3 : 0, 0); rd_err_idx = -1; wr_err_idx = -1;
            begin_run(1'b0, 4, 1'b0);
            for (int c = 0; c < 400 && !fe; c++) begin
                tick();
                while (obs_q.size() > 0) begin
                    got = obs_q.pop_front(); sk = skew_q.pop_front();
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    if (sk != want_skew) skew_bad++;
                    n_cmp++;
                    if (got !== want) begin
                        n_fail++; $display("FAIL aw_w_order_write[%0d]: got %h/%h, want %h/%h", m, got.addr, got.data, want.addr, want.data);
                    end
                end
            end
            n_cmp++;
            if (skew_bad != 0 || aw_cnt != 4 || w_cnt != 4 || !fe) begin
                n_fail++; $display("FAIL aw_w_order[%0d]: bad_skew=%0d aw=%0d w=%0d fetch=%b, want 0/4/4/1", m, skew_bad, aw_cnt, w_cnt, fe);
            end
        end
    endtask

    task automatic test_rresp_error();
        logic saw_fe = 1'b0;
        set_cfg(0, 0, 0, 0, 0); rd_err_idx = 2; wr_err_idx = -1;
        begin_run(1'b0, 2, 1'b0);
        for (int c = 0; c < 1100; c++) begin
            tick();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front(); sk = skew_q.pop_front();
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++; $display("FAIL rresp_err_write: got %h/%h, want %h/%h", got.addr, got.data, want.addr, want.data);
                end
            end
            if (fe) saw_fe = 1'b1;
        end
        n_cmp++;
        if (berr !== 1'b1 || wc !== 16'd2 || saw_fe !== 1'b0) begin
            n_fail++; $display("FAIL rresp_err_status: err=%b words=%0d fetch_seen=%b, want 1/2/0", berr, wc, saw_fe);
        end
        n_cmp++;
        if (aw_cnt != 2 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rresp_err_nowrite: aw=%0d unwritten=%0d, want 2/0", aw_cnt, exp_q.size());
        end
    endtask

    task automatic test_bresp_error();
        set_cfg(0, 0, 0, 0, 0); rd_err_idx = -1; wr_err_idx = 3;
        begin_run(1'b0, 4, 1'b0);
        for (int c = 0; c < 300; c++) begin
            tick();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front(); sk = skew_q.pop_front();
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++; $display("FAIL bresp_err_write: got %h/%h, want %h/%h", got.addr, got.data, want.addr, want.data);
                end
            end
        end
        n_cmp++;
        if (berr !== 1'b1 || wc !== 16'd3 || fe !== 1'b0) begin
            n_fail++; $display("FAIL bresp_err_status: err=%b words=%0d fetch=%b, want 1/3/0", berr, wc, fe);
        end
    endtask

    task automatic test_backpressure();
        logic early = 1'b0;
        set_cfg(-1, -1, -1, -1, -1); rd_err_idx = -1; wr_err_idx = -1;
        begin_run(1'b1, 64, 1'b0);
        for (int c = 0; c < 8000 && !fe; c++) begin
            tick();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front(); sk = skew_q.pop_front();
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++; $display("FAIL backpressure_write: got %h/%h/%h, want %h/%h/%h", got.addr, got.data, got.strb, want.addr, want.data, want.strb);
                end
            end
            if (fe && b_ok_cnt < 64) early = 1'b1;
        end
        n_cmp++;
        if (fe !== 1'b1 || early !== 1'b0 || wc !== 16'd64 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL backpressure_done: fetch=%b early=%b words=%0d unwritten=%0d, want 1/0/64/0", fe, early, wc, exp_q.size());
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_fail++; $display("FAIL backpressure_stable: %0d unstable valid cycles, want 0", stab_err);
        end
    endtask

    task automatic test_reset_mid_copy();
        set_cfg(0, 0, 0, 0, 0); rd_err_idx = -1; wr_err_idx = -1;
        begin_run(1'b1, 64, 1'b0);
        for (int c = 0; c < 500 && wc !== 16'd10; c++) tick();
        tick();
        #1;
        rst_v[1] = 1'b1;
        #1;
        n_cmp++;
        if ({arvalid, rready, awvalid, wvalid, bready, fe, berr} !== 7'b0 || wc !== 16'd0 ||
            {araddr, awaddr, wdata} !== 96'd0) begin
            n_fail++; $display("FAIL midreset_async: valids=%b words=%0d araddr=%h awaddr=%h wdata=%h, want all 0",
                               {arvalid, rready, awvalid, wvalid, bready}, wc, araddr, awaddr, wdata);
        end
        repeat (5) @(posedge clk);
        obs_q.delete(); skew_q.delete(); exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back({32'h4000 + 32'(4 * i), flash[i], 4'hF});
        @(negedge clk);
        rst_v[1] = 1'b0;
        for (int c = 0; c < 1000 && !fe; c++) begin
            tick();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front(); sk = skew_q.pop_front();
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++; $display("FAIL midreset_write: got %h/%h, want %h/%h", got.addr, got.data, want.addr, want.data);
                end
            end
        end
        n_cmp++;
        if (first_araddr !== 32'h2000) begin
            n_fail++; $display("FAIL midreset_restart: first araddr %h, want 00002000", first_araddr);
        end
        n_cmp++;
        if (fe !== 1'b1 || wc !== 16'd64 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL midreset_done: fetch=%b words=%0d unwritten=%0d, want 1/64/0", fe, wc, exp_q.size());
        end
    endtask

    initial begin
        sel = 1'b0;
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        rd_err_idx = -1;
        wr_err_idx = -1;
        test_reset();
        test_zero_wait();
        test_aw_w_order();
        test_rresp_error();
        test_bresp_error();
        test_backpressure();
        test_reset_mid_copy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
